// File: rtl/convolver_pkg.sv
// convolver_pkg: shared FSM state type and dimension limits for the line buffer.
`ifndef WID_FIFO
`define WID_FIFO 8
`endif
package convolver_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} lb_state_t;
  localparam int LB_MIN_DIM = 3;
endpackage

// File: rtl/line_buffer3_lb_mem.sv
// lb_mem: single-clock line memory with a registered, enabled read port (old data on same-address write).
`ifndef WID_FIFO
`define WID_FIFO 8
`endif
module lb_mem #(
  parameter int DEPTH = 256,
  parameter int W     = `WID_FIFO,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata_o <= '0;
    else if (re_i) rdata_o <= mem_q[raddr_i];
endmodule

// File: rtl/line_buffer3.sv
// line_buffer3: raster stream to 3-row vertical columns with 3x3 window-valid tracking.
// Optional LB_BACKPRESSURE_EN adds out_stall, which blocks accepts while the window pipeline keeps advancing.
`ifndef WID_FIFO
`define WID_FIFO 8
`endif
module line_buffer3
  import convolver_pkg::*;
#(
  parameter int MAX_COLS = 256,
  parameter int COL_W    = $clog2(MAX_COLS),
  parameter int ROW_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [COL_W:0]       cfg_cols,
  input  logic [ROW_W-1:0]     cfg_rows,
  input  logic                 in_valid,
  input  logic [`WID_FIFO-1:0] in_data,
`ifdef LB_BACKPRESSURE_EN
  input  logic                 out_stall,
`endif
  output logic                 in_ready,
  output logic [`WID_FIFO-1:0] col_top,
  output logic [`WID_FIFO-1:0] col_mid,
  output logic [`WID_FIFO-1:0] col_bot,
  output logic                 shifting,
  output logic                 win_valid,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 cfg_err
);
  lb_state_t state_q, state_d;
  logic [COL_W:0] cols_q, cols_d;
  logic [ROW_W-1:0] rows_q, rows_d, row_q, row_d;
  logic [COL_W-1:0] col_q, col_d, wcol_q;
  logic [`WID_FIFO-1:0] bot_q;
  logic shift_q, cfg_err_q, v1_q, v2_q;
  logic accept, legal, col_end, last, q;
`ifdef LB_BACKPRESSURE_EN
  assign in_ready = (state_q == RUN) && !out_stall;
`else
  assign in_ready = (state_q == RUN);
`endif
  assign accept  = in_valid && in_ready;
  assign legal   = cfg_cols >= (COL_W+1)'(LB_MIN_DIM) && cfg_cols <= (COL_W+1)'(MAX_COLS)
                   && cfg_rows >= ROW_W'(LB_MIN_DIM);
  assign col_end = {1'b0, col_q} == cols_q - (COL_W+1)'(1);
  assign last    = col_end && row_q == rows_q - ROW_W'(1);
  // Columns 0/1 of each row pair with stale shift-register taps; rows 0/1 read stale line memory.
  assign q       = accept && row_q >= ROW_W'(2) && col_q >= COL_W'(2);
  always_comb begin
    state_d = state_q;
    cols_d  = cols_q;
    rows_d  = rows_q;
    col_d   = col_q;
    row_d   = row_q;
    if (state_q == IDLE && start && legal) begin
      state_d = RUN;
      cols_d  = cfg_cols;
      rows_d  = cfg_rows;
      col_d   = '0;
      row_d   = '0;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (accept) begin
      col_d   = col_end ? '0 : col_q + COL_W'(1);
      row_d   = col_end ? row_q + ROW_W'(1) : row_q;
      state_d = last ? DONE : state_q;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      cols_q    <= '0;
      rows_q    <= '0;
      col_q     <= '0;
      row_q     <= '0;
      bot_q     <= '0;
      wcol_q    <= '0;
      shift_q   <= 1'b0;
      cfg_err_q <= 1'b0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cols_q    <= cols_d;
      rows_q    <= rows_d;
      col_q     <= col_d;
      row_q     <= row_d;
      bot_q     <= accept ? in_data : bot_q;
      wcol_q    <= accept ? col_q : wcol_q;
      shift_q   <= accept;
      cfg_err_q <= start && state_q == IDLE && !legal;
      v1_q      <= q;
      v2_q      <= v1_q;
    end
  lb_mem #(.DEPTH(MAX_COLS), .W(`WID_FIFO), .AW(COL_W)) lb0 (
    .clk(clk), .rst(rst),
    .re_i(accept), .raddr_i(col_q), .rdata_o(col_mid),
    .we_i(accept), .waddr_i(col_q), .wdata_i(in_data)
  );
  // The r-1 row reaches lb1 one cycle late, taken from lb0's read register.
  lb_mem #(.DEPTH(MAX_COLS), .W(`WID_FIFO), .AW(COL_W)) lb1 (
    .clk(clk), .rst(rst),
    .re_i(accept), .raddr_i(col_q), .rdata_o(col_top),
    .we_i(shift_q), .waddr_i(wcol_q), .wdata_i(col_mid)
  );
  assign col_bot    = bot_q;
  assign shifting   = shift_q;
  assign win_valid  = v2_q;
  assign busy       = state_q != IDLE;
  assign frame_done = state_q == DONE;
  assign cfg_err    = cfg_err_q;
endmodule

// File: tb/tb_line_buffer3.sv
// tb_line_buffer3: directed frames checked every cycle against an image-level model of line_buffer3.
`ifndef WID_FIFO
`define WID_FIFO 8
`endif
module tb_line_buffer3;
  localparam int W = `WID_FIFO;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, stall = 0;
  logic [8:0] cfg_cols = '0;
  logic [15:0] cfg_rows = '0;
  logic [W-1:0] in_data = '0;
  logic in_ready, shifting, win_valid, busy, frame_done, cfg_err;
  logic [W-1:0] col_top, col_mid, col_bot;
  int tests = 0, fails = 0, wcnt = 0, ecnt = 0, waits = 0, tag = 0;
  bit run_e = 0, done_e = 0, err_e = 0, shf_e = 0, w1 = 0, w2 = 0, tk = 1, mk = 1;
  bit idle, acc;
  int r = 0, c = 0, cols_e = 0, rows_e = 0;
  logic [W-1:0] top_e = '0, mid_e = '0, bot_e = '0;
  logic [W-1:0] img [0:7][0:255];

  always #5 clk = ~clk;

  line_buffer3 dut (
    .clk(clk), .rst(rst), .start(start), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
    .in_valid(in_valid), .in_data(in_data),
`ifdef LB_BACKPRESSURE_EN
    .out_stall(stall),
`endif
    .in_ready(in_ready), .col_top(col_top), .col_mid(col_mid), .col_bot(col_bot),
    .shifting(shifting), .win_valid(win_valid), .busy(busy), .frame_done(frame_done),
    .cfg_err(cfg_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit legal(input int cc, input int rr);
    return cc >= 3 && cc <= 256 && rr >= 3;
  endfunction

  // Model: rows r-1 / r-2 of the current frame sit directly above the accepted pixel.
  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outs", {in_ready, shifting, win_valid, busy, frame_done, cfg_err, col_top, col_mid, col_bot}, '0);
      run_e = 0; done_e = 0; err_e = 0; shf_e = 0; w1 = 0; w2 = 0;
      top_e = '0; mid_e = '0; bot_e = '0; tk = 1; mk = 1;
    end else begin
      chk("in_ready", in_ready, run_e && !stall);
      chk("busy", busy, run_e || done_e);
      chk("frame_done", frame_done, done_e);
      chk("cfg_err", cfg_err, err_e);
      chk("shifting", shifting, shf_e);
      chk("win_valid", win_valid, w2);
      chk("col_bot", col_bot, bot_e);
      if (mk) chk("col_mid", col_mid, mid_e);
      if (tk) chk("col_top", col_top, top_e);
      if (shf_e && (tag == 1 || tag == 2) && bot_e == W'(11))
        chk("pix11", {col_top, col_mid, col_bot}, {W'(3), W'(7), W'(11)});
      if (shf_e && tag == 3 && bot_e == W'(111))
        chk("pix111", {col_top, col_mid, col_bot}, {W'(103), W'(107), W'(111)});
      wcnt += int'(win_valid);
      ecnt += int'(cfg_err);
      idle = !run_e && !done_e;
      acc = in_valid && run_e && !stall;
      w2 = w1;
      w1 = acc && r >= 2 && c >= 2;
      shf_e = acc;
      err_e = start && idle && !legal(int'(cfg_cols), int'(cfg_rows));
      done_e = 0;
      if (acc) begin
        bot_e = in_data;
        mk = r >= 1;
        tk = r >= 2;
        if (mk) mid_e = img[r-1][c];
        if (tk) top_e = img[r-2][c];
        img[r][c] = in_data;
        done_e = (r == rows_e - 1) && (c == cols_e - 1);
        if (done_e) run_e = 0;
        c++;
        if (c == cols_e) begin c = 0; r++; end
      end
      if (start && idle && legal(int'(cfg_cols), int'(cfg_rows))) begin
        run_e = 1; r = 0; c = 0; cols_e = int'(cfg_cols); rows_e = int'(cfg_rows);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int cc, input int rr);
    cfg_cols = 9'(cc);
    cfg_rows = 16'(rr);
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic send(input int npix, input int base, input bit gap, input int stall_at);
    for (int i = 0; i < npix; i++) begin
      in_valid = 1;
      in_data = W'(base + i + 1);
      if (i == stall_at) begin
        stall = 1;
        repeat (3) begin chk("stall_ready", in_ready, 0); tick(); end
        stall = 0;
      end
      for (int k = 0; !in_ready; k++) begin
        if (k == 50) begin chk("accept_wait", in_ready, 1); in_valid = 0; return; end
        waits++;
        tick();
      end
      tick();
      in_valid = 0;
      if (gap) tick();
    end
  endtask

  initial begin
    repeat (2) tick();
    rst = 0;
    tick();
    tag = 1; wcnt = 0;
    do_start(4, 3);
    send(12, 0, 0, -1);
    chk("done_after_last", frame_done, 1);
    repeat (4) tick();
    chk("win_basic", wcnt, 2);
    tag = 2; wcnt = 0;
    do_start(4, 3);
    send(12, 0, 1, -1);
    repeat (4) tick();
    chk("win_gapped", wcnt, 2);
    tag = 0; ecnt = 0;
    do_start(2, 3);
    repeat (2) tick();
    chk("err_pulses", ecnt, 1);
    chk("err_busy", busy, 0);
    chk("err_ready", in_ready, 0);
    do_start(4, 3);
    send(6, 0, 0, -1);
    rst = 1;
    repeat (2) tick();
    rst = 0;
    tick();
    tag = 3; wcnt = 0;
    do_start(4, 3);
    send(12, 100, 0, -1);
    repeat (4) tick();
    chk("win_after_reset", wcnt, 2);
    tag = 0; wcnt = 0; waits = 0;
    do_start(256, 3);
    send(768, 0, 0, -1);
    repeat (4) tick();
    chk("win_max_width", wcnt, 254);
    chk("no_bubble", waits, 0);
`ifdef LB_BACKPRESSURE_EN
    tag = 1; wcnt = 0;
    do_start(4, 3);
    send(12, 0, 0, 5);
    repeat (4) tick();
    chk("win_stall", wcnt, 2);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
